u_cmt_buf: RTL and testbench

- Parametrised commit/writeback buffer for the execute pipeline.
- Holds DEPTH in-flight results, forwards them to NSRC operand readers and writes the register file from the oldest stage.
- Loads are held in the oldest stage until the LSU handshakes data; the buffer stalls the pipe while it waits.
- Load data is aligned and sign- or zero-extended per funct3 (LB/LH/LW/LBU/LHU), with a same-cycle bypass of returning load data to the forwarding ports.

---
 rtl/exe_pkg.sv | 24 ++
 rtl/u_ld_fmt.sv | 31 +++
 rtl/u_cmt_buf.sv | 120 ++++++++++++
 tb/tb_u_cmt_buf.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared execute-pipeline types: load funct3 codes and the
// commit-buffer entry layout used by u_cmt_buf.
package exe_pkg;

    localparam int CMT_XLEN = 32;
    localparam int CMT_AW   = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                vld;
        logic                we;
        logic                ld;
        logic [CMT_AW-1:0]   a;
        logic [CMT_XLEN-1:0] d;
        logic [2:0]          f3;
        logic [1:0]          boff;
    } cmt_ent_t;

endpackage

// File: rtl/u_ld_fmt.sv
// Load data formatter: selects byte/half by offset and
// sign- or zero-extends it according to funct3.
module u_ld_fmt
    import exe_pkg::*;
#(
    parameter int XLEN = CMT_XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      f3,
    input  logic [1:0]      boff,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{boff, 3'b000} +: 8];
        h    = boff[1] ? word[16 +: 16] : word[0 +: 16];
        data = word;
        case (f3)
            F3_LB:   data = {{(XLEN-8){b[7]}}, b};
            F3_LH:   data = {{(XLEN-16){h[15]}}, h};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/u_cmt_buf.sv
// Commit/writeback buffer: DEPTH-stage result shift register with
// operand forwarding and a load-data wait at the oldest stage.
module u_cmt_buf
    import exe_pkg::*;
#(
    parameter int XLEN  = CMT_XLEN,
    parameter int AW    = CMT_AW,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_vld,
    input  logic                 in_we,
    input  logic                 in_ld,
    input  logic [AW-1:0]        in_a,
    input  logic [XLEN-1:0]      in_d,
    input  logic [2:0]           in_f3,
    input  logic [1:0]           in_boff,
    output logic                 in_rdy,
    input  logic                 flush_i,
    output logic                 stall_o,
    input  logic                 lsu_vld,
    input  logic [XLEN-1:0]      lsu_rd,
    input  logic [NSRC*AW-1:0]   src_a,
    input  logic [NSRC*XLEN-1:0] src_d,
    output logic [NSRC*XLEN-1:0] fwd_d,
    output logic [NSRC-1:0]      fwd_no_dat,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_a,
    output logic [XLEN-1:0]      rf_d
);

    cmt_ent_t        stg [DEPTH];
    cmt_ent_t        head;
    cmt_ent_t        ins;
    logic [XLEN-1:0] cmt_d;
    logic [XLEN-1:0] byp_d;

    assign head    = stg[DEPTH-1];
    assign stall_o = head.vld & head.ld & ~lsu_vld;
    assign in_rdy  = ~stall_o;

    // Loads always write rd unless rd is x0.
    always_comb begin
        ins      = '0;
        ins.vld  = in_vld & ~flush_i;
        ins.we   = (in_we | in_ld) & (in_a != '0);
        ins.ld   = in_ld;
        ins.a    = in_a;
        ins.d    = in_d;
        ins.f3   = in_f3;
        ins.boff = in_boff;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg[k] <= '0;
            end
        end else if (!stall_o) begin
            stg[0] <= ins;
            for (int k = 1; k < DEPTH; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    u_ld_fmt #(.XLEN(XLEN)) u_fmt_cmt (
        .word (lsu_rd),
        .f3   (head.f3),
        .boff (head.boff),
        .data (cmt_d)
    );

    u_ld_fmt #(.XLEN(XLEN)) u_fmt_byp (
        .word (lsu_rd),
        .f3   (head.f3),
        .boff (head.boff),
        .data (byp_d)
    );

    // Gate load data so rf_d does not follow lsu_rd while waiting.
    always_comb begin
        rf_we = head.vld & head.we & (~head.ld | lsu_vld);
        rf_a  = head.a;
        rf_d  = head.d;
        if (head.ld) begin
            rf_d = lsu_vld ? cmt_d : '0;
        end
    end

    logic          hit;
    logic [AW-1:0] sa;

    always_comb begin
        fwd_d      = src_d;
        fwd_no_dat = '0;
        hit        = 1'b0;
        sa         = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit = 1'b0;
            sa  = src_a[i*AW +: AW];
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit && stg[k].vld && stg[k].we &&
                    stg[k].a == sa && sa != '0) begin
                    hit = 1'b1;
                    if (!stg[k].ld) begin
                        fwd_d[i*XLEN +: XLEN] = stg[k].d;
                    end else if (k == DEPTH-1 && lsu_vld) begin
                        fwd_d[i*XLEN +: XLEN] = byp_d;
                    end else begin
                        fwd_no_dat[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_u_cmt_buf.sv
// Self-checking bench for u_cmt_buf: scenario tasks plus a
// scoreboard that checks every register-file write in order.
module tb_u_cmt_buf;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_vld = 0, in_we = 0, in_ld = 0;
    logic [4:0]  in_a = 0;
    logic [31:0] in_d = 0;
    logic [2:0]  in_f3 = 0;
    logic [1:0]  in_boff = 0;
    logic        in_rdy;
    logic        flush_i = 0;
    logic        stall_o;
    logic        lsu_vld = 0;
    logic [31:0] lsu_rd = 0;
    logic [9:0]  src_a = 0;
    logic [63:0] src_d = 0;
    logic [63:0] fwd_d;
    logic [1:0]  fwd_no_dat;
    logic        rf_we;
    logic [4:0]  rf_a;
    logic [31:0] rf_d;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    u_cmt_buf dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_vld     (in_vld),
        .in_we      (in_we),
        .in_ld      (in_ld),
        .in_a       (in_a),
        .in_d       (in_d),
        .in_f3      (in_f3),
        .in_boff    (in_boff),
        .in_rdy     (in_rdy),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .lsu_vld    (lsu_vld),
        .lsu_rd     (lsu_rd),
        .src_a      (src_a),
        .src_d      (src_d),
        .fwd_d      (fwd_d),
        .fwd_no_dat (fwd_no_dat),
        .rf_we      (rf_we),
        .rf_a       (rf_a),
        .rf_d       (rf_d)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && rf_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected rf_a=%0d rf_d=%h", rf_a, rf_d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rf_a !== e.a || rf_d !== e.d) begin
                    failures++;
                    $display("FAIL sb_write got a=%0d d=%h want a=%0d d=%h",
                             rf_a, rf_d, e.a, e.d);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_vld  = 0;
        in_we   = 0;
        in_ld   = 0;
        flush_i = 0;
    endtask

    task automatic test_reset();
        src_a = 0;
        src_d = 64'h1111_2222_3333_4444;
        @(negedge clk);
        checks++;
        if (stall_o !== 0 || rf_we !== 0 || rf_a !== 0 ||
            rf_d !== 0 || fwd_no_dat !== 0 || in_rdy !== 1) begin
            failures++;
            $display("FAIL reset_outs got st=%b we=%b a=%0d d=%h nd=%b rdy=%b want 0 0 0 0 0 1",
                     stall_o, rf_we, rf_a, rf_d, fwd_no_dat, in_rdy);
        end
        checks++;
        if (fwd_d !== 64'h1111_2222_3333_4444) begin
            failures++;
            $display("FAIL reset_fwd got %h want %h", fwd_d, 64'h1111_2222_3333_4444);
        end
    endtask

    task automatic test_alu();
        cyc();
        src_a[4:0] = 5;
        src_d[31:0] = 32'h5555_5555;
        in_vld = 1; in_we = 1; in_a = 5; in_d = 32'h1234;
        sb.push_back('{5'd5, 32'h1234});
        cyc();
        idle_in();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== (c == 2)) begin
                failures++;
                $display("FAIL alu_lat cyc=%0d got rf_we=%b want %b", c, rf_we, c == 2);
            end
            checks++;
            if (fwd_d[31:0] !== 32'h1234 || fwd_no_dat[0] !== 0) begin
                failures++;
                $display("FAIL alu_fwd cyc=%0d got %h nd=%b want 00001234 0",
                         c, fwd_d[31:0], fwd_no_dat[0]);
            end
            cyc();
        end
        src_a = 0;
    endtask

    task automatic test_back_to_back();
        src_a[9:5] = 7;
        src_d[63:32] = 32'h7777_7777;
        in_vld = 1; in_we = 1; in_a = 7; in_d = 32'hA;
        sb.push_back('{5'd7, 32'hA});
        cyc();
        in_d = 32'hB;
        sb.push_back('{5'd7, 32'hB});
        cyc();
        idle_in();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (fwd_d[63:32] !== 32'hB) begin
                failures++;
                $display("FAIL b2b_youngest cyc=%0d got %h want 0000000b", c, fwd_d[63:32]);
            end
            cyc();
        end
        repeat (2) cyc();
        src_a = 0;
    endtask

    task automatic test_load_stall();
        lsu_vld = 0;
        lsu_rd = 32'h80FF_0000;
        in_vld = 1; in_ld = 1; in_a = 3; in_f3 = 3'b000; in_boff = 3;
        sb.push_back('{5'd3, 32'hFFFF_FF80});
        cyc();
        idle_in();
        cyc();
        cyc();
        // Head holds the load now; this insert must be dropped.
        in_vld = 1; in_we = 1; in_a = 9; in_d = 32'h99;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (stall_o !== 1 || in_rdy !== 0 || rf_we !== 0) begin
                failures++;
                $display("FAIL ld_stall cyc=%0d got st=%b rdy=%b we=%b want 1 0 0",
                         c, stall_o, in_rdy, rf_we);
            end
            cyc();
        end
        idle_in();
        lsu_vld = 1;
        @(negedge clk);
        checks++;
        if (stall_o !== 0 || rf_we !== 1 || rf_d !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL ld_commit got st=%b we=%b d=%h want 0 1 ffffff80",
                     stall_o, rf_we, rf_d);
        end
        cyc();
        lsu_vld = 0;
        repeat (3) cyc();
    endtask

    task automatic test_load_bypass();
        src_a[4:0] = 4;
        src_d[31:0] = 32'h4444_4444;
        lsu_rd = 32'hBEEF_0000;
        in_vld = 1; in_ld = 1; in_a = 4; in_f3 = 3'b101; in_boff = 2;
        sb.push_back('{5'd4, 32'h0000_BEEF});
        cyc();
        idle_in();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (fwd_no_dat[0] !== 1 || fwd_d[31:0] !== 32'h4444_4444) begin
                failures++;
                $display("FAIL ld_nodat cyc=%0d got nd=%b d=%h want 1 44444444",
                         c, fwd_no_dat[0], fwd_d[31:0]);
            end
            cyc();
        end
        lsu_vld = 1;
        @(negedge clk);
        checks++;
        if (fwd_no_dat[0] !== 0 || fwd_d[31:0] !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL ld_bypass got nd=%b d=%h want 0 0000beef",
                     fwd_no_dat[0], fwd_d[31:0]);
        end
        cyc();
        lsu_vld = 0;
        src_a = 0;
        repeat (3) cyc();
    endtask

    task automatic test_flush_x0();
        src_a[4:0] = 6;
        src_d[31:0] = 32'h6666_6666;
        in_vld = 1; in_we = 1; in_a = 6; in_d = 32'h60; flush_i = 1;
        cyc();
        idle_in();
        @(negedge clk);
        checks++;
        if (fwd_d[31:0] !== 32'h6666_6666 || fwd_no_dat !== 0) begin
            failures++;
            $display("FAIL flush_fwd got %h nd=%b want 66666666 0", fwd_d[31:0], fwd_no_dat);
        end
        cyc();
        src_a[4:0] = 0;
        src_d[31:0] = 32'h0BAD_0000;
        in_vld = 1; in_we = 1; in_a = 0; in_d = 32'hDEAD;
        cyc();
        idle_in();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 0 || fwd_d[31:0] !== 32'h0BAD_0000) begin
                failures++;
                $display("FAIL x0_entry cyc=%0d got we=%b d=%h want 0 0bad0000",
                         c, rf_we, fwd_d[31:0]);
            end
            cyc();
        end
    endtask

    task automatic test_reset_stall();
        lsu_vld = 0;
        lsu_rd = 32'h1234_5678;
        in_vld = 1; in_ld = 1; in_a = 8; in_f3 = 3'b010;
        cyc();
        idle_in();
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (stall_o !== 1) begin
            failures++;
            $display("FAIL rst_pre got st=%b want 1", stall_o);
        end
        #1 rstn = 0;
        #1;
        checks++;
        if (stall_o !== 0 || rf_we !== 0 || rf_a !== 0 ||
            rf_d !== 0 || in_rdy !== 1) begin
            failures++;
            $display("FAIL rst_mid got st=%b we=%b a=%0d d=%h rdy=%b want 0 0 0 0 1",
                     stall_o, rf_we, rf_a, rf_d, in_rdy);
        end
        cyc();
        rstn = 1;
        lsu_vld = 1;
        repeat (4) cyc();
        lsu_vld = 0;
    endtask

    initial begin
        #12 rstn = 1;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_stall();
        test_load_bypass();
        test_flush_x0();
        test_reset_stall();
        repeat (2) cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
